// File: rtl/atp_change_dispenser_if.sv
// Purpose: note presentation handshake between the change dispenser and the note mechanism.
// Latency: none, signal bundle only.
// Backpressure: the mechanism holds off a presented note simply by not raising note_ack.
interface atp_change_dispenser_if;
    logic       note_valid;
    logic [2:0] note_code;
    logic       note_ack;

    modport master (output note_valid, output note_code, input note_ack);
    modport slave  (input note_valid, input note_code, output note_ack);
endinterface

// File: rtl/atp_change_dispenser.sv
// Purpose: greedy refund payout from a per-denomination note inventory; ATP_DISPENSE_TIMEOUT_EN adds an ack timeout/FAULT state.
// Latency: 1 SELECT cycle per note plus ack wait; zero refund reports done 2 cycles after start.
// Backpressure: a presented note (and the whole payout) stalls until note_ack; deposits are accepted every cycle.
module atp_change_dispenser #(
    parameter int AMT_W          = 16,
    parameter int STOCK_W        = 8,
    parameter int INIT_STOCK     = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AMT_W-1:0]    refund_amount,
    input  logic                note_in_valid,
    input  logic [2:0]          note_in_code,
    input  logic                stock_load,
    input  logic [2:0]          stock_sel,
    input  logic [STOCK_W-1:0]  stock_value,
    atp_change_dispenser_if.master note_if,
    output logic                busy,
    output logic                done,
    output logic                short,
    output logic [AMT_W-1:0]    short_amount,
    output logic [AMT_W-1:0]    remaining,
    output logic                fault
);

    typedef enum logic [2:0] {IDLE, SELECT, DISPENSE, DONE, FAULT} state_t;

    state_t             state, next_state;
    logic [STOCK_W-1:0] stock [6];
    logic [2:0]         note_code_q;
    logic               pick_found;
    logic [2:0]         pick_code;
    logic               ack_take;
    logic               timeout_hit;

    function automatic logic [AMT_W-1:0] denom_value(input logic [2:0] code);
        case (code)
            3'd0:    return AMT_W'(10);
            3'd1:    return AMT_W'(20);
            3'd2:    return AMT_W'(50);
            3'd3:    return AMT_W'(100);
            3'd4:    return AMT_W'(200);
            3'd5:    return AMT_W'(500);
            default: return '0;
        endcase
    endfunction

    assign ack_take = (state == DISPENSE) && note_if.note_ack;

`ifdef ATP_DISPENSE_TIMEOUT_EN
    logic [31:0] timer;

    // Count cycles spent waiting for the mechanism on the current note.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timer <= '0;
        else if (state == DISPENSE)
            timer <= timer + 32'd1;
        else
            timer <= '0;
    end

    assign timeout_hit = (state == DISPENSE) && !note_if.note_ack &&
                         (timer == 32'(TIMEOUT_CYCLES - 1));
    assign fault       = (state == FAULT);
`else
    assign timeout_hit = 1'b0;
    assign fault       = 1'b0;
`endif

    // Greedy pick: highest-valued denomination in stock that still fits the remainder.
    always_comb begin
        pick_found = 1'b0;
        pick_code  = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (stock[i] != '0 && denom_value(3'(i)) <= remaining) begin
                pick_found = 1'b1;
                pick_code  = 3'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        next_state         = state;
        note_if.note_valid = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    next_state = SELECT;
            end
            SELECT: begin
                busy = 1'b1;
                if (remaining == '0)
                    next_state = DONE;
                else if (pick_found)
                    next_state = DISPENSE;
                else
                    next_state = DONE;
            end
            DISPENSE: begin
                busy               = 1'b1;
                note_if.note_valid = 1'b1;
                if (note_if.note_ack)
                    next_state = SELECT;
                else if (timeout_hit)
                    next_state = FAULT;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            FAULT: begin
                busy = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    assign note_if.note_code = note_code_q;

    // Payout datapath: remainder, shortfall report and the presented denomination.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining    <= '0;
            short        <= 1'b0;
            short_amount <= '0;
            note_code_q  <= 3'd0;
        end else begin
            if (state == IDLE && start) begin
                remaining    <= refund_amount;
                short        <= 1'b0;
                short_amount <= '0;
            end
            if (state == SELECT && remaining != '0) begin
                if (pick_found) begin
                    note_code_q <= pick_code;
                end else begin
                    short        <= 1'b1;
                    short_amount <= remaining;
                end
            end
            if (ack_take)
                remaining <= remaining - denom_value(note_code_q);
        end
    end

    // Inventory: load (IDLE only) beats deposit; deposit and dispense of one denomination cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 6; i++)
                stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (stock_load && state == IDLE && stock_sel == 3'(i))
                    stock[i] <= stock_value;
                else if ((note_in_valid && note_in_code == 3'(i)) &&
                         !(ack_take && note_code_q == 3'(i))) begin
                    if (stock[i] != '1)
                        stock[i] <= stock[i] + 1'b1;
                end else if (!(note_in_valid && note_in_code == 3'(i)) &&
                             (ack_take && note_code_q == 3'(i)))
                    stock[i] <= stock[i] - 1'b1;
            end
        end
    end

endmodule
